// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane alignment, byte enables and load extension over a mem_resp handshake.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of truncating the lane offset.
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_byte_enable,
  input  logic              mem_resp,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic              stall
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  logic            r_write;
  logic            r_unsigned;
  logic            r_flushed;
  logic [1:0]      r_size;
  logic [OB-1:0]   r_off;
  logic [4:0]      r_rd;

  logic [1:0]      w_size;
  logic            w_unsup;
  logic            w_fault;
  logic            w_accept;
  logic [OB-1:0]   w_lowmask;
  logic [OB-1:0]   w_off;
  logic [NB-1:0]   w_be_base;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_load;

  assign w_size   = req_funct3[1:0];
  assign w_accept = req_valid && (r_state == S_IDLE) && !flush;

  always_comb begin
    w_unsup = 1'b0;
    if (req_funct3 == 3'b111)
      w_unsup = 1'b1;
    if ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
      w_unsup = 1'b1;
    if (req_write && req_funct3[2])
      w_unsup = 1'b1;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = ((w_size == 2'd1) && req_addr[0]) ||
                   ((w_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                   ((w_size == 2'd3) && (req_addr[2:0] != 3'b000));
  assign w_fault = w_unsup || w_misal;
`else
  assign w_fault = w_unsup;
`endif

  // Offset is forced to natural alignment; aligned accesses are unaffected.
  always_comb begin
    w_lowmask = '0;
    w_be_base = '1;
    case (w_size)
      2'd0:    begin w_lowmask = '0;       w_be_base = NB'(1);  end
      2'd1:    begin w_lowmask = OB'(1);   w_be_base = NB'(3);  end
      2'd2:    begin w_lowmask = OB'(3);   w_be_base = NB'(15); end
      default: begin w_lowmask = '1;       w_be_base = '1;      end
    endcase
  end

  assign w_off   = req_addr[OB-1:0] & ~w_lowmask;
  assign w_be    = w_be_base << w_off;
  assign w_wdata = req_wdata << {w_off, 3'b000};
  assign w_shift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'd0:    w_load = r_unsigned ? XLEN'(w_shift[7:0])  : XLEN'($signed(w_shift[7:0]));
      2'd1:    w_load = r_unsigned ? XLEN'(w_shift[15:0]) : XLEN'($signed(w_shift[15:0]));
      2'd2:    w_load = r_unsigned ? XLEN'(w_shift[31:0]) : XLEN'($signed(w_shift[31:0]));
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_write         <= 1'b0;
      r_unsigned      <= 1'b0;
      r_flushed       <= 1'b0;
      r_size          <= '0;
      r_off           <= '0;
      r_rd            <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      rsp_data        <= '0;
      rsp_rd          <= '0;
      rsp_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_unsigned <= req_funct3[2];
            r_size     <= w_size;
            r_off      <= w_off;
            r_rd       <= req_rd;
            r_flushed  <= 1'b0;
            if (w_fault) begin
              r_state   <= S_RESP;
              rsp_fault <= 1'b1;
              rsp_data  <= '0;
              rsp_rd    <= req_rd;
            end else begin
              r_state         <= S_ACCESS;
              mem_read        <= !req_write;
              mem_write       <= req_write;
              mem_address     <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
              mem_wdata       <= req_write ? w_wdata : '0;
              mem_byte_enable <= w_be;
            end
          end
        end
        S_ACCESS: begin
          if (flush)
            r_flushed <= 1'b1;
          // A flush anywhere in the access lets memory finish but drops the response.
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (r_flushed || flush) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_RESP;
              rsp_fault <= 1'b0;
              rsp_data  <= r_write ? '0 : w_load;
              rsp_rd    <= r_rd;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign stall     = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP) && !flush;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit that sits between the EX/MEM pipeline register and the data memory (data cache) port. It accepts one memory request at a time and performs byte-lane alignment, byte-enable generation and load sign/zero extension for XLEN of 32 or 64. Unlike a single-cycle magic-memory path, it runs a multi-cycle `mem_resp` handshake and raises `stall` while an access is outstanding. It also supports flushing a pending result and reporting misaligned or unsupported accesses.

## Interface
- `XLEN`, 32: data width; legal values 32 or 64. `NB = XLEN/8` byte lanes; `OB = log2(NB)` offset bits.
- `ADDR_W`, 32: address width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  XLEN  store data, right-justified.
- `req_rd`  in  5  destination register tag, echoed on response.
- `flush`  in  1  kill the current or incoming request's response.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_address`  out  ADDR_W  address with low OB bits forced to 0.
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_byte_enable`  out  NB  byte lanes written.
- `mem_resp`  in  1  memory completion, one-cycle pulse.
- `mem_rdata`  in  XLEN  read data, valid with `mem_resp`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  XLEN  extended load data; 0 for stores and faults.
- `rsp_rd`  out  5  echoed tag.
- `rsp_fault`  out  1  misaligned access or unsupported funct3.
- `stall`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
  - `req_ready = (state == IDLE)`.
  - A request is accepted when `req_valid & req_ready & !flush`. On acceptance, the unit latches `write`, `funct3`, `addr`, `wdata` and `rd`.
- **Legality check at acceptance:**
  - Unsupported: funct3 011, 110 or 111 when XLEN=32. Funct3 111 is unsupported when XLEN=64. Store funct3 ≥ 100 is unsupported for either width.
  - Misaligned: a half access with `addr[0] != 0`; a word access with `addr[1:0] != 0`; a double access with `addr[2:0] != 0`.
  - Illegal requests go IDLE→RESP with `rsp_fault=1`. No memory strobe is issued.
- **Legal requests:** IDLE→ACCESS.
  - Registered `mem_read` or `mem_write`, `mem_address`, `mem_wdata` and `mem_byte_enable` are held constant until `mem_resp`.
  - On `mem_resp`: strobes clear on the same edge, load data is captured, and the FSM goes ACCESS→RESP.
- **RESP:** `rsp_valid=1` for one cycle, then the FSM returns to IDLE.
- **Lane rule:** `off = addr[OB-1:0]`.
  - Stores: `mem_wdata = req_wdata << (8*off)`. Byte enable is 1, 2, 4 or 8 set bits shifted left by `off`.
  - Loads: select `mem_rdata >> (8*off)`, then sign-extend (b/h/w) or zero-extend (bu/hu/wu) to XLEN. d passes through unchanged.
- **Flush:**
  - In IDLE, flush blocks acceptance.
  - In ACCESS, the memory transaction still completes (strobes held until `mem_resp`), but the response is dropped and the FSM goes directly to IDLE.
  - In RESP, `rsp_valid` is suppressed.
  - A flushed store still writes memory. Upstream must not flush committed stores.
- **Reset:** an asynchronous reset drops the FSM to IDLE at any point, including mid-access. A late `mem_resp` arriving in IDLE is ignored.

## Timing
- **Reset values:**
  - `req_ready` = 1.
  - `stall`, `mem_read`, `mem_write`, `rsp_valid` and `rsp_fault` = 0.
  - `mem_address`, `mem_wdata`, `mem_byte_enable`, `rsp_data` and `rsp_rd` = 0.
- **Legal access, accepted at edge 0:**
  - Strobes are high from cycle 1.
  - If `mem_resp` arrives in cycle k ≥ 1, `rsp_valid` is high in cycle k+1.
  - Minimum latency is 2 cycles. Maximum throughput is one request per 3 cycles.
- **Fault:** accepted at edge 0, `rsp_valid` with `rsp_fault` in cycle 1.
- **Stall:** `stall` is high from cycle 1 through the RESP cycle inclusive.
- **Stable outputs:** `rsp_data`, `rsp_rd` and `rsp_fault` are registered and remain stable until the next response.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** misaligned accesses fault as described above.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - Misaligned accesses are not faulted. They proceed to memory with `off` truncated to natural alignment; for example, lh at offset 1 is treated as offset 0.
  - `rsp_fault` is asserted only for unsupported funct3.

## Test plan
1. XLEN=32, lw at 0x100, `mem_resp` in cycle 1 with `mem_rdata=0xDEADBEEF` → `mem_address=0x100` and `mem_read` high in cycle 1 only; in cycle 2, `rsp_valid=1`, `rsp_data=0xDEADBEEF`, `rsp_rd` echoed.
2. lb at 0x103 with `mem_rdata=0x80FF0000` → `rsp_data=0xFFFFFF80`. lbu at the same address → `0x00000080`.
3. sh at 0x102 with `wdata=0x1234ABCD` → `mem_address=0x100`, `mem_wdata=0xABCD0000`, `mem_byte_enable=4'b1100`.
4. lh at 0x101:
   - Macro defined → no `mem_read`; in cycle 1, `rsp_valid=1`, `rsp_fault=1`, `rsp_data=0`.
   - Macro undefined → read of 0x100 using lane 0.
5. lw accepted, `flush` in cycle 1, `mem_resp` delayed to cycle 4 → `mem_read` high in cycles 1–4, no `rsp_valid`, `req_ready=1` from cycle 5. Asserting `rst` in cycle 2 instead → strobes drop immediately.
6. XLEN=64:
   - ld at 0x8 → `mem_byte_enable=8'hFF`.
   - lw at 0xC with `mem_rdata=0x80000000_00000000` → `rsp_data=0xFFFFFFFF80000000`.
   - lwu at the same address → `0x0000000080000000`.
